// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

    // Counter width for a WIDTH-bit word, never narrower than one bit.
    function automatic int cw_of(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/shift_reg_n.sv
// WIDTH-bit serial-in shift register with enable, synchronous clear and direction select.
module shift_reg_n #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (shift_en) begin
            // MSB_FIRST pushes toward the top so the first bit ends in q[WIDTH-1].
            q <= MSB_FIRST ? {q[WIDTH-2:0], din} : {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with a one-entry valid/ready output buffer
// and a sticky overrun flag for words dropped while the buffer was full.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CW        = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             busy,
    output logic             overrun
);

    sipo_state_t      state, state_nxt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] cand;
    logic             accept;
    logic             complete;
    logic             buf_free;

    assign accept   = din_valid && !clear;
    assign complete = accept && (bit_cnt == CW'(WIDTH - 1));
    assign buf_free = !dout_valid || dout_ready;

    // The completed word includes the bit being accepted this cycle.
    assign cand = MSB_FIRST ? {sh[WIDTH-2:0], din} : {din, sh[WIDTH-1:1]};

    shift_reg_n #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .clr     (clear),
        .shift_en(accept),
        .din     (din),
        .q       (sh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (clear || complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
        end else if (accept) begin
            bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
        end
    end

    // Output buffer: a load may coincide with a drain; otherwise a drain empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (complete && buf_free) begin
            dout       <= cand;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overrun <= 1'b0;
        end else if (complete && !buf_free) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: two instances (MSB-first and LSB-first) share one stimulus
// stream and are compared every cycle against a bit-queue reference model.
module tb_sipo_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         clear = 1'b0;
    logic         dout_ready = 1'b0;

    logic [W-1:0] dout_a, dout_b;
    logic         dout_valid_a, dout_valid_b;
    logic [2:0]   bit_cnt_a, bit_cnt_b;
    logic         busy_a, busy_b;
    logic         overrun_a, overrun_b;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state: bits of the partial word in arrival order plus the buffer.
    bit       q_bits[$];
    int       m_dout[2] = '{0, 0};
    bit       m_vld = 1'b0;
    bit       m_ovr = 1'b0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .dout      (dout_a),
        .dout_valid(dout_valid_a),
        .dout_ready(dout_ready),
        .bit_cnt   (bit_cnt_a),
        .busy      (busy_a),
        .overrun   (overrun_a)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .dout      (dout_b),
        .dout_valid(dout_valid_b),
        .dout_ready(dout_ready),
        .bit_cnt   (bit_cnt_b),
        .busy      (busy_b),
        .overrun   (overrun_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit loaded;
        bit drain;
        int wm, wl;
        if (rst) begin
            q_bits.delete();
            m_dout[0] = 0;
            m_dout[1] = 0;
            m_vld     = 1'b0;
            m_ovr     = 1'b0;
        end else begin
            loaded = 1'b0;
            drain  = m_vld && dout_ready;
            if (clear) begin
                q_bits.delete();
                m_ovr = 1'b0;
            end else if (din_valid) begin
                q_bits.push_back(din);
                if (q_bits.size() == W) begin
                    wm = 0;
                    wl = 0;
                    for (int i = 0; i < W; i++) begin
                        wm += int'(q_bits[i]) << (W - 1 - i);
                        wl += int'(q_bits[i]) << i;
                    end
                    q_bits.delete();
                    if (!m_vld || dout_ready) begin
                        m_dout[0] = wm;
                        m_dout[1] = wl;
                        m_vld     = 1'b1;
                        loaded    = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
            if (drain && !loaded) m_vld = 1'b0;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.dout",       int'(dout_a),       m_dout[0]);
            chk("b.dout",       int'(dout_b),       m_dout[1]);
            chk("a.dout_valid", int'(dout_valid_a), int'(m_vld));
            chk("b.dout_valid", int'(dout_valid_b), int'(m_vld));
            chk("a.bit_cnt",    int'(bit_cnt_a),    q_bits.size());
            chk("b.bit_cnt",    int'(bit_cnt_b),    q_bits.size());
            chk("a.busy",       int'(busy_a),       int'(q_bits.size() != 0));
            chk("b.busy",       int'(busy_b),       int'(q_bits.size() != 0));
            chk("a.overrun",    int'(overrun_a),    int'(m_ovr));
            chk("b.overrun",    int'(overrun_b),    int'(m_ovr));
        end
    end

    task automatic cyc(input logic v, input logic b, input logic c, input logic r);
        rst        = 1'b0;
        din_valid  = v;
        din        = b;
        clear      = c;
        dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc();
        rst       = 1'b1;
        din_valid = 1'($urandom);
        din       = 1'($urandom);
        clear     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic r, input logic r_last,
                             input int maxgap);
        for (int i = W - 1; i >= 0; i--) begin
            repeat ($urandom_range(maxgap, 0)) cyc(1'b0, 1'($urandom), 1'b0, r);
            cyc(1'b1, w[i], 1'b0, (i == 0) ? r_last : r);
        end
    endtask

    initial begin
        logic [W-1:0] pat;
        rst_cyc();
        rst_cyc();
        chk_en = 1'b1;
        chk("reset.dout_valid", int'(dout_valid_a), 0);
        chk("reset.dout", int'(dout_a), 0);

        // Plain word, consecutive bits
        pat = 8'hC0;
        send_word(pat, 1'b1, 1'b1, 0);
        chk("t1.a.dout", int'(dout_a), 8'hC0);
        chk("t1.b.dout", int'(dout_b), 8'h03);
        chk("t1.valid", int'(dout_valid_a), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1.valid_one_cycle", int'(dout_valid_a), 0);
        chk("t1.dout_kept", int'(dout_a), 8'hC0);

        // Same word with idle gaps; bit_cnt must step 1..7 then wrap
        for (int i = W - 1; i >= 0; i--) begin
            repeat ($urandom_range(3, 0)) cyc(1'b0, 1'($urandom), 1'b0, 1'b1);
            cyc(1'b1, pat[i], 1'b0, 1'b1);
            chk("t2.bit_cnt", int'(bit_cnt_a), (W - i) % W);
        end
        chk("t2.a.dout", int'(dout_a), 8'hC0);
        chk("t2.b.dout", int'(dout_b), 8'h03);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun while buffer held
        send_word(8'h3C, 1'b0, 1'b0, 1);
        send_word(8'h81, 1'b0, 1'b0, 1);
        chk("t3.dout_held", int'(dout_a), 8'h3C);
        chk("t3.valid", int'(dout_valid_a), 1);
        chk("t3.overrun", int'(overrun_a), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3.drained", int'(dout_valid_a), 0);
        chk("t3.overrun_sticky", int'(overrun_a), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3.overrun_cleared", int'(overrun_a), 0);

        // Simultaneous drain and load
        send_word(8'h3C, 1'b0, 1'b0, 0);
        send_word(8'h81, 1'b0, 1'b1, 0);
        chk("t4.dout", int'(dout_a), 8'h81);
        chk("t4.valid", int'(dout_valid_a), 1);
        chk("t4.overrun", int'(overrun_a), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Clear aborts a partial word, bit on the clear cycle discarded
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5.cnt_after_clear", int'(bit_cnt_a), 0);
        send_word(8'h5A, 1'b1, 1'b1, 0);
        chk("t5.a.dout", int'(dout_a), 8'h5A);
        chk("t5.b.dout", int'(dout_b), 8'h5A);
        chk("t5.bit_cnt", int'(bit_cnt_a), 0);
        chk("t5.busy", int'(busy_a), 0);
        chk("t5.overrun", int'(overrun_a), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset with a pending word and a partial word
        send_word(8'h11, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        rst_cyc();
        chk("t6.dout", int'(dout_a), 0);
        chk("t6.valid", int'(dout_valid_a), 0);
        chk("t6.bit_cnt", int'(bit_cnt_a), 0);
        chk("t6.busy", int'(busy_a), 0);
        send_word(8'hA7, 1'b1, 1'b1, 2);
        chk("t6.a.dout", int'(dout_a), 8'hA7);
        chk("t6.b.dout", int'(dout_b), 8'hE5);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399, 0) == 0) begin
                rst_cyc();
            end else begin
                cyc(1'($urandom_range(9, 0) < 7), 1'($urandom),
                    1'($urandom_range(49, 0) == 0), 1'($urandom_range(9, 0) < 6));
            end
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
